apb_req_arbiter: RTL and testbench

APB_REQ_ARBITER -- requirements
Module: apb_req_arbiter

---
 rtl/apb_arb_pkg.sv | 17 +
 rtl/apb_req_arbiter_if.sv | 45 ++++
 rtl/rr_picker.sv | 26 ++
 rtl/apb_req_arbiter.sv | 123 ++++++++++++
 tb/tb_apb_req_arbiter.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/apb_arb_pkg.sv
// Shared state type, default sizing and pointer helper for the APB request arbiter.
package apb_arb_pkg;

    localparam int ARB_NREQ    = 4;
    localparam int ARB_DW      = 8;
    localparam int ARB_TIMEOUT = 16;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

    function automatic int rr_next(input int idx, input int n);
        return (idx + 1) % n;
    endfunction

endpackage

// File: rtl/apb_req_arbiter_if.sv
// Requester, APB-master and APB-monitor signals of the arbiter; the arbiter
// uses the slave modport, the requesters/bus side uses the master modport.
interface apb_req_arbiter_if
    import apb_arb_pkg::*;
#(
    parameter int NREQ = ARB_NREQ,
    parameter int DW   = ARB_DW
);

    logic [NREQ-1:0]          req_valid;
    logic [NREQ-1:0][DW-1:0]  req_data;
    logic [NREQ-1:0][1:0]     req_dest;
    logic [NREQ-1:0]          req_error;
    logic [NREQ-1:0]          req_ack;
    logic                     resp_drop;
    logic                     resp_timeout;

    logic [DW-1:0]            m_data;
    logic                     m_data_ready;
    logic                     m_alu_error;
    logic [1:0]               m_protocol_sel;

    logic                     psel_any;
    logic                     penable;
    logic                     pready;

    logic                     busy;

    modport slave (
        input  req_valid, req_data, req_dest, req_error,
        input  psel_any, penable, pready,
        output req_ack, resp_drop, resp_timeout,
        output m_data, m_data_ready, m_alu_error, m_protocol_sel,
        output busy
    );

    modport master (
        output req_valid, req_data, req_dest, req_error,
        output psel_any, penable, pready,
        input  req_ack, resp_drop, resp_timeout,
        input  m_data, m_data_ready, m_alu_error, m_protocol_sel,
        input  busy
    );

endinterface

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set request bit at or after ptr, wrapping.
module rr_picker
    import apb_arb_pkg::*;
#(
    parameter  int NREQ = ARB_NREQ,
    localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
)(
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic            valid,
    output logic [PW-1:0]   idx
);

    // Walking from the far end back toward ptr leaves the nearest hit as the final assignment.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[PW'((int'(ptr) + i) % NREQ)]) begin
                valid = 1'b1;
                idx   = PW'((int'(ptr) + i) % NREQ);
            end
        end
    end

endmodule

// File: rtl/apb_req_arbiter.sv
// Round-robin arbiter funnelling NREQ requesters into one APB master, with
// error-drop and transfer-timeout completion reporting.
module apb_req_arbiter
    import apb_arb_pkg::*;
#(
    parameter int NREQ    = ARB_NREQ,
    parameter int DW      = ARB_DW,
    parameter int TIMEOUT = ARB_TIMEOUT
)(
    input  logic             PCLK,
    input  logic             PRESET,
    apb_req_arbiter_if.slave arb
);

    localparam int            PW       = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int            CW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);

    arb_state_e      state_q, state_d;
    logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [PW-1:0]   grant_q, grant_d;
    logic [CW-1:0]   tmo_cnt_q, tmo_cnt_d;
    logic [NREQ-1:0] ack_q, ack_d;
    logic            drop_q, drop_d;
    logic            tmo_q, tmo_d;
    logic [DW-1:0]   data_q, data_d;
    logic [1:0]      sel_q, sel_d;

    logic            done;
    logic [NREQ-1:0] pick_req;
    logic            pick_valid;
    logic [PW-1:0]   pick_idx;

    assign done = arb.psel_any & arb.penable & arb.pready;

    // A requester still holds req_valid during its ack cycle; hide it so it is not granted twice.
    assign pick_req = arb.req_valid & ~ack_q;

    rr_picker #(.NREQ(NREQ)) u_picker (
        .req   (pick_req),
        .ptr   (rr_ptr_q),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        grant_d   = grant_q;
        tmo_cnt_d = tmo_cnt_q;
        ack_d     = '0;
        drop_d    = 1'b0;
        tmo_d     = 1'b0;
        data_d    = data_q;
        sel_d     = sel_q;

        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    rr_ptr_d = PW'(rr_next(int'(pick_idx), NREQ));
                    if (arb.req_error[pick_idx]) begin
                        ack_d[pick_idx] = 1'b1;
                        drop_d          = 1'b1;
                    end else begin
                        data_d    = arb.req_data[pick_idx];
                        sel_d     = arb.req_dest[pick_idx];
                        grant_d   = pick_idx;
                        tmo_cnt_d = '0;
                        state_d   = BUSY;
                    end
                end
            end
            BUSY: begin
                // done is tested first so completion on the last allowed cycle is not reported as a timeout.
                if (done) begin
                    state_d        = IDLE;
                    ack_d[grant_q] = 1'b1;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    state_d        = IDLE;
                    ack_d[grant_q] = 1'b1;
                    tmo_d          = 1'b1;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q   <= IDLE;
            rr_ptr_q  <= '0;
            grant_q   <= '0;
            tmo_cnt_q <= '0;
            ack_q     <= '0;
            drop_q    <= 1'b0;
            tmo_q     <= 1'b0;
            data_q    <= '0;
            sel_q     <= '0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            grant_q   <= grant_d;
            tmo_cnt_q <= tmo_cnt_d;
            ack_q     <= ack_d;
            drop_q    <= drop_d;
            tmo_q     <= tmo_d;
            data_q    <= data_d;
            sel_q     <= sel_d;
        end
    end

    assign arb.req_ack        = ack_q;
    assign arb.resp_drop      = drop_q;
    assign arb.resp_timeout   = tmo_q;
    assign arb.m_data         = data_q;
    assign arb.m_protocol_sel = sel_q;
    assign arb.m_alu_error    = 1'b0;
    assign arb.busy           = (state_q == BUSY);
    assign arb.m_data_ready   = (state_q == BUSY) & ~done;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Directed bench for apb_req_arbiter: inputs change 1ns after each rising edge,
// outputs are checked at that same point before the new inputs are applied.
module tb_apb_req_arbiter;

    localparam int NREQ    = 4;
    localparam int DW      = 8;
    localparam int TIMEOUT = 16;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    logic [7:0] exp_data  [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    logic [1:0] exp_dest  [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
    int         exp_order [5] = '{0, 1, 2, 3, 0};

    apb_req_arbiter_if #(.NREQ(NREQ), .DW(DW)) arb_if ();

    apb_req_arbiter #(.NREQ(NREQ), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
        .PCLK   (clk),
        .PRESET (rst),
        .arb    (arb_if)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [NREQ-1:0] valid, input logic [NREQ-1:0] err,
                                 input logic psel, input logic pen, input logic rdy);
        arb_if.req_valid = valid;
        arb_if.req_error = err;
        arb_if.psel_any  = psel;
        arb_if.penable   = pen;
        arb_if.pready    = rdy;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_ack"},   32'(arb_if.req_ack),        0);
        checkOutput({tag, "_drop"},  32'(arb_if.resp_drop),      0);
        checkOutput({tag, "_tmo"},   32'(arb_if.resp_timeout),   0);
        checkOutput({tag, "_data"},  32'(arb_if.m_data),         0);
        checkOutput({tag, "_ready"}, 32'(arb_if.m_data_ready),   0);
        checkOutput({tag, "_sel"},   32'(arb_if.m_protocol_sel), 0);
        checkOutput({tag, "_alu"},   32'(arb_if.m_alu_error),    0);
        checkOutput({tag, "_busy"},  32'(arb_if.busy),           0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1;
        arb_if.req_data = '0;
        arb_if.req_dest = '0;
        applyStimulus(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
        step();
        step();
        checkAllZero("reset");
        rst = 1'b0;

        // Single transfer from requester 0
        arb_if.req_data[0] = 8'hA5;
        arb_if.req_dest[0] = 2'd2;
        applyStimulus(4'b0001, 4'b0000, 1'b0, 1'b0, 1'b0);
        step();
        checkOutput("t1_busy",  32'(arb_if.busy),           1);
        checkOutput("t1_data",  32'(arb_if.m_data),         'hA5);
        checkOutput("t1_sel",   32'(arb_if.m_protocol_sel), 2);
        checkOutput("t1_ready", 32'(arb_if.m_data_ready),   1);
        checkOutput("t1_ack0",  32'(arb_if.req_ack),        0);
        applyStimulus(4'b0001, 4'b0000, 1'b1, 1'b0, 1'b0);
        step();
        checkOutput("t1_setup_busy",  32'(arb_if.busy),         1);
        checkOutput("t1_setup_ready", 32'(arb_if.m_data_ready), 1);
        applyStimulus(4'b0001, 4'b0000, 1'b1, 1'b1, 1'b1);
        #1;
        checkOutput("t1_done_ready", 32'(arb_if.m_data_ready), 0);
        step();
        checkOutput("t1_ack",   32'(arb_if.req_ack),      'b0001);
        checkOutput("t1_drop",  32'(arb_if.resp_drop),    0);
        checkOutput("t1_tmo",   32'(arb_if.resp_timeout), 0);
        checkOutput("t1_idle",  32'(arb_if.busy),         0);
        checkOutput("t1_hold",  32'(arb_if.m_data),       'hA5);
        applyStimulus(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
        step();
        checkOutput("t1_ack_end", 32'(arb_if.req_ack), 0);

        // Round robin with all four requesting continuously
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            arb_if.req_data[i] = exp_data[i];
            arb_if.req_dest[i] = exp_dest[i];
        end
        applyStimulus(4'b1111, 4'b0000, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            step();
            checkOutput($sformatf("rr%0d_busy", k), 32'(arb_if.busy),           1);
            checkOutput($sformatf("rr%0d_data", k), 32'(arb_if.m_data),         32'(exp_data[exp_order[k]]));
            checkOutput($sformatf("rr%0d_sel", k),  32'(arb_if.m_protocol_sel), 32'(exp_dest[exp_order[k]]));
            checkOutput($sformatf("rr%0d_noack", k), 32'(arb_if.req_ack),       0);
            applyStimulus(4'b1111, 4'b0000, 1'b1, 1'b1, 1'b1);
            step();
            checkOutput($sformatf("rr%0d_ack", k),  32'(arb_if.req_ack), 1 << exp_order[k]);
            checkOutput($sformatf("rr%0d_gap", k),  32'(arb_if.busy),    0);
            applyStimulus((k == 4) ? 4'b0000 : 4'b1111, 4'b0000, 1'b0, 1'b0, 1'b0);
        end
        step();
        checkOutput("rr_end_ack",  32'(arb_if.req_ack), 0);
        checkOutput("rr_end_busy", 32'(arb_if.busy),    0);

        // Errored request from requester 2 is dropped; pointer moves to 3
        applyStimulus(4'b0100, 4'b0100, 1'b0, 1'b0, 1'b0);
        #1;
        checkOutput("drop_ready_pre", 32'(arb_if.m_data_ready), 0);
        step();
        checkOutput("drop_ack",   32'(arb_if.req_ack),      'b0100);
        checkOutput("drop_flag",  32'(arb_if.resp_drop),    1);
        checkOutput("drop_tmo",   32'(arb_if.resp_timeout), 0);
        checkOutput("drop_busy",  32'(arb_if.busy),         0);
        checkOutput("drop_ready", 32'(arb_if.m_data_ready), 0);
        applyStimulus(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
        step();
        checkOutput("drop_ack_end",  32'(arb_if.req_ack),   0);
        checkOutput("drop_flag_end", 32'(arb_if.resp_drop), 0);
        applyStimulus(4'b1001, 4'b0000, 1'b0, 1'b0, 1'b0);
        step();
        checkOutput("ptr3_busy", 32'(arb_if.busy),   1);
        checkOutput("ptr3_data", 32'(arb_if.m_data), 'h44);
        applyStimulus(4'b1001, 4'b0000, 1'b1, 1'b1, 1'b1);
        step();
        checkOutput("ptr3_ack", 32'(arb_if.req_ack), 'b1000);
        applyStimulus(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
        step();

        // Requester 1 never sees pready: 16 busy cycles then a timeout ack
        applyStimulus(4'b0010, 4'b0000, 1'b0, 1'b0, 1'b0);
        step();
        checkOutput("tmo_busy",  32'(arb_if.busy),           1);
        checkOutput("tmo_data",  32'(arb_if.m_data),         'h22);
        checkOutput("tmo_sel",   32'(arb_if.m_protocol_sel), 2);
        applyStimulus(4'b0010, 4'b0000, 1'b1, 1'b1, 1'b0);
        for (int k = 0; k < TIMEOUT - 1; k++) step();
        checkOutput("tmo_last_busy",  32'(arb_if.busy),         1);
        checkOutput("tmo_last_ready", 32'(arb_if.m_data_ready), 1);
        checkOutput("tmo_last_noack", 32'(arb_if.req_ack),      0);
        step();
        checkOutput("tmo_ack",  32'(arb_if.req_ack),      'b0010);
        checkOutput("tmo_flag", 32'(arb_if.resp_timeout), 1);
        checkOutput("tmo_drop", 32'(arb_if.resp_drop),    0);
        checkOutput("tmo_idle", 32'(arb_if.busy),         0);
        applyStimulus(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
        step();
        checkOutput("tmo_ack_end",  32'(arb_if.req_ack),      0);
        checkOutput("tmo_flag_end", 32'(arb_if.resp_timeout), 0);

        // Completion lands on the final allowed cycle: normal ack wins
        applyStimulus(4'b0010, 4'b0000, 1'b0, 1'b0, 1'b0);
        step();
        checkOutput("race_busy", 32'(arb_if.busy), 1);
        applyStimulus(4'b0010, 4'b0000, 1'b1, 1'b1, 1'b0);
        for (int k = 0; k < TIMEOUT - 1; k++) step();
        applyStimulus(4'b0010, 4'b0000, 1'b1, 1'b1, 1'b1);
        step();
        checkOutput("race_ack",  32'(arb_if.req_ack),      'b0010);
        checkOutput("race_tmo",  32'(arb_if.resp_timeout), 0);
        checkOutput("race_idle", 32'(arb_if.busy),         0);
        applyStimulus(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
        step();

        // Reset in the middle of a transfer abandons it silently
        applyStimulus(4'b0001, 4'b0000, 1'b0, 1'b0, 1'b0);
        step();
        checkOutput("rstb_busy", 32'(arb_if.busy),   1);
        checkOutput("rstb_data", 32'(arb_if.m_data), 'h11);
        applyStimulus(4'b0001, 4'b0000, 1'b1, 1'b1, 1'b0);
        step();
        step();
        rst = 1'b1;
        step();
        checkAllZero("rstb");
        rst = 1'b0;
        applyStimulus(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
        step();
        checkOutput("rstb_noack1", 32'(arb_if.req_ack), 0);
        step();
        checkOutput("rstb_noack2", 32'(arb_if.req_ack), 0);
        checkOutput("rstb_idle",   32'(arb_if.busy),    0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
